// File: rtl/ssd1306_pkg.sv
// Shared SSD1306 opcode constants, memory-mode encodings and the argument-count lookup
// used by the SPI responder decode logic.
package ssd1306_pkg;

  localparam logic [7:0] OP_MEM_MODE       = 8'h20;
  localparam logic [7:0] OP_COL_ADDR       = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR      = 8'h22;
  localparam logic [7:0] OP_CONTRAST       = 8'h81;
  localparam logic [7:0] OP_CHARGE_PUMP    = 8'h8D;
  localparam logic [7:0] OP_SEG_REMAP0     = 8'hA0;
  localparam logic [7:0] OP_SEG_REMAP1     = 8'hA1;
  localparam logic [7:0] OP_ENTIRE_OFF     = 8'hA4;
  localparam logic [7:0] OP_ENTIRE_ON      = 8'hA5;
  localparam logic [7:0] OP_NORMAL         = 8'hA6;
  localparam logic [7:0] OP_INVERT         = 8'hA7;
  localparam logic [7:0] OP_MUX_RATIO      = 8'hA8;
  localparam logic [7:0] OP_DISPLAY_OFF    = 8'hAE;
  localparam logic [7:0] OP_DISPLAY_ON     = 8'hAF;
  localparam logic [7:0] OP_PAGE_START     = 8'hB0;
  localparam logic [7:0] OP_COM_SCAN_INC   = 8'hC0;
  localparam logic [7:0] OP_COM_SCAN_DEC   = 8'hC8;
  localparam logic [7:0] OP_DISPLAY_OFFSET = 8'hD3;
  localparam logic [7:0] OP_CLK_DIV        = 8'hD5;
  localparam logic [7:0] OP_PRECHARGE      = 8'hD9;
  localparam logic [7:0] OP_COM_PINS       = 8'hDA;
  localparam logic [7:0] OP_VCOMH          = 8'hDB;

  localparam logic [1:0] MemHoriz = 2'd0;
  localparam logic [1:0] MemVert  = 2'd1;
  localparam logic [1:0] MemPage  = 2'd2;

  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      OP_CONTRAST, OP_CHARGE_PUMP, OP_MUX_RATIO, OP_DISPLAY_OFFSET, OP_CLK_DIV,
      OP_PRECHARGE, OP_COM_PINS, OP_VCOMH, OP_MEM_MODE: arg_count = 2'd1;
      OP_COL_ADDR, OP_PAGE_ADDR:                        arg_count = 2'd2;
      default:                                          arg_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ssd1306_spi_rx_shift.sv
// Oversampling SPI mode-0 receiver: synchronises the serial lines, detects sclk rising edges
// and assembles MSB-first bytes, presenting each completed byte with a one-cycle valid pulse.
module ssd1306_spi_rx_shift #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       sclk,
  input  logic       sdin,
  input  logic       dc,
  input  logic       cs_n,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_dc
);

  logic [SYNC_STAGES-1:0] sclk_sync, sdin_sync, dc_sync, cs_sync;
  logic                   sclk_prev_q, cs_prev_q;
  logic [6:0]             shift_q;
  logic [2:0]             cnt_q;
  logic                   sclk_s, sdin_s, dc_s, cs_s, sclk_rise;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign sdin_s = sdin_sync[SYNC_STAGES-1];
  assign dc_s   = dc_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  // An edge that coincides with cs_n rising is still accepted so a final bit is not lost.
  assign sclk_rise = sclk_s & ~sclk_prev_q & ~(cs_s & cs_prev_q);

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      sclk_sync   <= '0;
      sdin_sync   <= '0;
      dc_sync     <= '0;
      cs_sync     <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      shift_q     <= '0;
      cnt_q       <= '0;
      rx_valid    <= 1'b0;
      rx_byte     <= '0;
      rx_dc       <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdin_sync   <= {sdin_sync[SYNC_STAGES-2:0], sdin};
      dc_sync     <= {dc_sync[SYNC_STAGES-2:0], dc};
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      rx_valid    <= 1'b0;
      if (sclk_rise) begin
        shift_q <= {shift_q[5:0], sdin_s};
        cnt_q   <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          rx_byte  <= {shift_q, sdin_s};
          rx_dc    <= dc_s;
          rx_valid <= 1'b1;
        end
      end else if (cs_s) begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/ssd1306_spi_responder.sv
// SSD1306 panel-side SPI responder: decodes command bytes into a shadow register set and turns
// data bytes into GDDRAM write strobes with the controller's address auto-increment.
module ssd1306_spi_responder
  import ssd1306_pkg::*;
#(
  parameter int unsigned COLS        = 128,
  parameter int unsigned PAGES       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned CW = $clog2(COLS),
  localparam int unsigned PW = $clog2(PAGES),
  localparam int unsigned AW = $clog2(COLS * PAGES)
) (
  input  logic          clk_50M,
  input  logic          rst,
  input  logic          oled_sclk,
  input  logic          oled_sdin,
  input  logic          oled_dc,
  input  logic          oled_cs_n,
  output logic          rx_valid,
  output logic [7:0]    rx_byte,
  output logic          rx_dc,
  output logic          cmd_done,
  output logic          cmd_unknown,
  output logic          display_on,
  output logic          entire_on,
  output logic          invert,
  output logic          seg_remap,
  output logic          com_scan_dec,
  output logic [7:0]    contrast,
  output logic [5:0]    mux_ratio,
  output logic [5:0]    display_offset,
  output logic [5:0]    start_line,
  output logic          charge_pump,
  output logic [1:0]    mem_mode,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StArg1 = 2'd1;
  localparam logic [1:0] StArg2 = 2'd2;

  ssd1306_spi_rx_shift #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk_50M (clk_50M),
    .rst     (rst),
    .sclk    (oled_sclk),
    .sdin    (oled_sdin),
    .dc      (oled_dc),
    .cs_n    (oled_cs_n),
    .rx_valid(rx_valid),
    .rx_byte (rx_byte),
    .rx_dc   (rx_dc)
  );

  logic [1:0]    state_q, state_d;
  logic [7:0]    op_q, op_d, arg1_q, arg1_d;
  logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic [7:0]    col_ext;
  logic          display_on_d, entire_on_d, invert_d, seg_remap_d, com_scan_dec_d;
  logic          charge_pump_d, cmd_done_d, cmd_unknown_d, ram_we_d;
  logic [7:0]    contrast_d, ram_wdata_d;
  logic [5:0]    mux_ratio_d, display_offset_d, start_line_d;
  logic [1:0]    mem_mode_d;
  logic [AW-1:0] ram_addr_d;

  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    arg1_d           = arg1_q;
    col_d            = col_q;
    page_d           = page_q;
    col_start_d      = col_start_q;
    col_end_d        = col_end_q;
    page_start_d     = page_start_q;
    page_end_d       = page_end_q;
    col_ext          = 8'(col_q);
    display_on_d     = display_on;
    entire_on_d      = entire_on;
    invert_d         = invert;
    seg_remap_d      = seg_remap;
    com_scan_dec_d   = com_scan_dec;
    contrast_d       = contrast;
    mux_ratio_d      = mux_ratio;
    display_offset_d = display_offset;
    start_line_d     = start_line;
    charge_pump_d    = charge_pump;
    mem_mode_d       = mem_mode;
    cmd_done_d       = 1'b0;
    cmd_unknown_d    = 1'b0;
    ram_we_d         = 1'b0;
    ram_addr_d       = ram_addr;
    ram_wdata_d      = ram_wdata;

    if (rx_valid && rx_dc) begin
      // Data abandons any half-received command.
      state_d     = StIdle;
      ram_we_d    = 1'b1;
      ram_addr_d  = AW'(page_q) * AW'(COLS) + AW'(col_q);
      ram_wdata_d = rx_byte;
      unique case (mem_mode)
        MemHoriz: begin
          if (col_q == col_end_q) begin
            col_d  = col_start_q;
            page_d = (page_q == page_end_q) ? page_start_q : page_q + PW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
        MemVert: begin
          if (page_q == page_end_q) begin
            page_d = page_start_q;
            col_d  = (col_q == col_end_q) ? col_start_q : col_q + CW'(1);
          end else begin
            page_d = page_q + PW'(1);
          end
        end
        default: col_d = (col_q == col_end_q) ? col_start_q : col_q + CW'(1);
      endcase
    end else if (rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (arg_count(rx_byte) != 2'd0) begin
            op_d    = rx_byte;
            state_d = StArg1;
          end else begin
            cmd_done_d = 1'b1;
            if (rx_byte[7:6] == 2'b01) begin
              start_line_d = rx_byte[5:0];
            end else if (rx_byte[7:4] == 4'h0) begin
              col_ext[3:0] = rx_byte[3:0];
              col_d        = CW'(col_ext);
            end else if (rx_byte[7:4] == 4'h1) begin
              col_ext[7:4] = rx_byte[3:0];
              col_d        = CW'(col_ext);
            end else if (rx_byte[7:4] == OP_PAGE_START[7:4] && 32'(rx_byte[3:0]) < PAGES) begin
              page_d = PW'(rx_byte[3:0]);
            end else begin
              case (rx_byte)
                OP_DISPLAY_OFF:  display_on_d   = 1'b0;
                OP_DISPLAY_ON:   display_on_d   = 1'b1;
                OP_ENTIRE_OFF:   entire_on_d    = 1'b0;
                OP_ENTIRE_ON:    entire_on_d    = 1'b1;
                OP_NORMAL:       invert_d       = 1'b0;
                OP_INVERT:       invert_d       = 1'b1;
                OP_SEG_REMAP0:   seg_remap_d    = 1'b0;
                OP_SEG_REMAP1:   seg_remap_d    = 1'b1;
                OP_COM_SCAN_INC: com_scan_dec_d = 1'b0;
                OP_COM_SCAN_DEC: com_scan_dec_d = 1'b1;
                default: begin
                  cmd_done_d    = 1'b0;
                  cmd_unknown_d = 1'b1;
                end
              endcase
            end
          end
        end
        StArg1: begin
          if (arg_count(op_q) == 2'd2) begin
            arg1_d  = rx_byte;
            state_d = StArg2;
          end else begin
            state_d    = StIdle;
            cmd_done_d = 1'b1;
            case (op_q)
              OP_CONTRAST:       contrast_d       = rx_byte;
              OP_CHARGE_PUMP:    charge_pump_d    = rx_byte[2];
              OP_MUX_RATIO:      mux_ratio_d      = rx_byte[5:0];
              OP_DISPLAY_OFFSET: display_offset_d = rx_byte[5:0];
              OP_MEM_MODE:       if (rx_byte[1:0] != 2'd3) mem_mode_d = rx_byte[1:0];
              default:           ;
            endcase
          end
        end
        StArg2: begin
          state_d    = StIdle;
          cmd_done_d = 1'b1;
          if (op_q == OP_COL_ADDR) begin
            col_start_d = CW'(arg1_q);
            col_end_d   = CW'(rx_byte);
            col_d       = CW'(arg1_q);
          end else begin
            page_start_d = PW'(arg1_q);
            page_end_d   = PW'(rx_byte);
            page_d       = PW'(arg1_q);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q        <= StIdle;
      op_q           <= '0;
      arg1_q         <= '0;
      col_q          <= '0;
      page_q         <= '0;
      col_start_q    <= '0;
      col_end_q      <= CW'(COLS - 1);
      page_start_q   <= '0;
      page_end_q     <= PW'(PAGES - 1);
      display_on     <= 1'b0;
      entire_on      <= 1'b0;
      invert         <= 1'b0;
      seg_remap      <= 1'b0;
      com_scan_dec   <= 1'b0;
      contrast       <= 8'h7F;
      mux_ratio      <= 6'h3F;
      display_offset <= '0;
      start_line     <= '0;
      charge_pump    <= 1'b0;
      mem_mode       <= MemPage;
      cmd_done       <= 1'b0;
      cmd_unknown    <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      arg1_q         <= arg1_d;
      col_q          <= col_d;
      page_q         <= page_d;
      col_start_q    <= col_start_d;
      col_end_q      <= col_end_d;
      page_start_q   <= page_start_d;
      page_end_q     <= page_end_d;
      display_on     <= display_on_d;
      entire_on      <= entire_on_d;
      invert         <= invert_d;
      seg_remap      <= seg_remap_d;
      com_scan_dec   <= com_scan_dec_d;
      contrast       <= contrast_d;
      mux_ratio      <= mux_ratio_d;
      display_offset <= display_offset_d;
      start_line     <= start_line_d;
      charge_pump    <= charge_pump_d;
      mem_mode       <= mem_mode_d;
      cmd_done       <= cmd_done_d;
      cmd_unknown    <= cmd_unknown_d;
      ram_we         <= ram_we_d;
      ram_addr       <= ram_addr_d;
      ram_wdata      <= ram_wdata_d;
    end
  end

endmodule

// File: tb/tb_ssd1306_spi_responder.sv
// Scoreboard bench: bit-bangs SPI bytes into the responder, predicts each byte's effect with a
// command-queue reference model and checks the received byte and its decode one cycle later.
module tb_ssd1306_spi_responder;

  localparam int COLS  = 128;
  localparam int PAGES = 8;
  localparam int AW    = 10;

  logic clk = 1'b0, rst = 1'b1;
  logic sclk = 1'b0, sdin = 1'b0, dc = 1'b0, cs_n = 1'b0;
  logic          rx_valid, rx_dc, cmd_done, cmd_unknown;
  logic [7:0]    rx_byte, contrast, ram_wdata;
  logic          display_on, entire_on, invert, seg_remap, com_scan_dec, charge_pump, ram_we;
  logic [5:0]    mux_ratio, display_offset, start_line;
  logic [1:0]    mem_mode;
  logic [AW-1:0] ram_addr;

  always #10 clk = ~clk;

  ssd1306_spi_responder #(
    .COLS(COLS), .PAGES(PAGES), .SYNC_STAGES(2)
  ) dut (
    .clk_50M(clk), .rst(rst), .oled_sclk(sclk), .oled_sdin(sdin), .oled_dc(dc),
    .oled_cs_n(cs_n), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_dc(rx_dc),
    .cmd_done(cmd_done), .cmd_unknown(cmd_unknown), .display_on(display_on),
    .entire_on(entire_on), .invert(invert), .seg_remap(seg_remap),
    .com_scan_dec(com_scan_dec), .contrast(contrast), .mux_ratio(mux_ratio),
    .display_offset(display_offset), .start_line(start_line), .charge_pump(charge_pump),
    .mem_mode(mem_mode), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata)
  );

  logic [33:0] dut_regs;
  assign dut_regs = {display_on, entire_on, invert, seg_remap, com_scan_dec, contrast, mux_ratio,
                     display_offset, start_line, charge_pump, mem_mode};

  typedef struct packed {
    logic [7:0]    b;
    logic          dc;
    logic          done;
    logic          unk;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic [33:0]   regs;
  } exp_t;

  exp_t expq[$];
  int checks = 0, errors = 0;

  // Reference model state
  logic       m_disp, m_ent, m_inv, m_seg, m_com, m_cp;
  logic [7:0] m_contrast;
  logic [5:0] m_mux, m_off, m_sl;
  logic [1:0] m_mm;
  int m_col, m_page, m_cs, m_ce, m_ps, m_pe;
  logic [7:0] cmdq[$];

  logic [7:0] ops [30] = '{8'hAE, 8'hAF, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA0, 8'hA1, 8'hC0,
                           8'hC8, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hDA, 8'h20, 8'h20,
                           8'h21, 8'h22, 8'hB0, 8'hB3, 8'hB7, 8'hB8, 8'h00, 8'h0F, 8'h10,
                           8'h17, 8'h40, 8'h7F};

  function automatic logic [33:0] model_regs();
    return {m_disp, m_ent, m_inv, m_seg, m_com, m_contrast, m_mux, m_off, m_sl, m_cp, m_mm};
  endfunction

  function automatic int nargs(logic [7:0] op);
    case (op)
      8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h20: return 1;
      8'h21, 8'h22: return 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    {m_disp, m_ent, m_inv, m_seg, m_com, m_cp} = '0;
    m_contrast = 8'h7F; m_mux = 6'h3F; m_off = 0; m_sl = 0; m_mm = 2'd2;
    m_col = 0; m_page = 0; m_cs = 0; m_ce = COLS - 1; m_ps = 0; m_pe = PAGES - 1;
    cmdq.delete();
  endtask

  task automatic model_byte(logic [7:0] b, logic d);
    exp_t e;
    logic [7:0] op, a1, a2;
    e = '0; e.b = b; e.dc = d;
    if (d) begin
      cmdq.delete();
      e.we = 1'b1; e.addr = AW'(m_page * COLS + m_col); e.wdata = b;
      if (m_mm == 2'd1) begin
        if (m_page == m_pe) begin
          m_page = m_ps;
          m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % COLS;
        end else m_page = (m_page + 1) % PAGES;
      end else if (m_col == m_ce) begin
        m_col = m_cs;
        if (m_mm == 2'd0) m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % PAGES;
      end else m_col = (m_col + 1) % COLS;
    end else begin
      cmdq.push_back(b);
      if (cmdq.size() == 1 + nargs(cmdq[0])) begin
        op = cmdq[0];
        a1 = (cmdq.size() > 1) ? cmdq[1] : 8'h00;
        a2 = (cmdq.size() > 2) ? cmdq[2] : 8'h00;
        e.done = 1'b1;
        if (op >= 8'h40 && op <= 8'h7F) m_sl = op[5:0];
        else if (op <= 8'h0F) m_col = (m_col / 16) * 16 + op;
        else if (op <= 8'h1F) m_col = ((op - 16) * 16 + m_col % 16) % COLS;
        else if (op >= 8'hB0 && op < 8'hB0 + PAGES) m_page = op - 8'hB0;
        else case (op)
          8'hAE: m_disp = 0;  8'hAF: m_disp = 1;
          8'hA4: m_ent = 0;   8'hA5: m_ent = 1;
          8'hA6: m_inv = 0;   8'hA7: m_inv = 1;
          8'hA0: m_seg = 0;   8'hA1: m_seg = 1;
          8'hC0: m_com = 0;   8'hC8: m_com = 1;
          8'h81: m_contrast = a1;
          8'h8D: m_cp = a1[2];
          8'hA8: m_mux = a1[5:0];
          8'hD3: m_off = a1[5:0];
          8'h20: if (a1[1:0] != 2'd3) m_mm = a1[1:0];
          8'h21: begin m_cs = a1 % COLS; m_ce = a2 % COLS; m_col = m_cs; end
          8'h22: begin m_ps = a1 % PAGES; m_pe = a2 % PAGES; m_page = m_ps; end
          8'hD5, 8'hD9, 8'hDA, 8'hDB: ;
          default: begin e.done = 1'b0; e.unk = 1'b1; end
        endcase
        cmdq.delete();
      end
    end
    e.regs = model_regs();
    expq.push_back(e);
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one prediction per received byte, checks decode on the following cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rx_valid) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rx: got byte %0h with no prediction pending", rx_byte);
        end else begin
          e = expq.pop_front();
          check("rx_byte", rx_byte, e.b);
          check("rx_dc", rx_dc, e.dc);
          @(negedge clk);
          check("cmd_done", cmd_done, e.done);
          check("cmd_unknown", cmd_unknown, e.unk);
          check("ram_we", ram_we, e.we);
          if (e.we) begin
            check("ram_addr", ram_addr, e.addr);
            check("ram_wdata", ram_wdata, e.wdata);
          end
          check("regs", dut_regs, e.regs);
        end
      end
    end
  end

  task automatic send_bit(logic v);
    sdin = v;
    repeat (3) @(posedge clk);
    sclk = 1'b1;
    repeat (3) @(posedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b, logic d);
    model_byte(b, d);
    dc = d;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    repeat (4) @(posedge clk);
  endtask

  task automatic partial(int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
    repeat (2) @(posedge clk);
    cs_n = 1'b1;
    repeat (6) @(posedge clk);
    cs_n = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_reset();
  endtask

  task automatic check_reset();
    @(negedge clk);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_cmd_done", cmd_done, 1'b0);
    check("rst_cmd_unknown", cmd_unknown, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_regs", dut_regs, model_regs());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d predictions pending",
             expq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset();

    send_byte(8'hAF, 0);
    send_byte(8'h81, 0); send_byte(8'h3C, 0);
    send_byte(8'h20, 0); send_byte(8'h00, 0);
    send_byte(8'h21, 0); send_byte(8'h7E, 0); send_byte(8'h7F, 0);
    send_byte(8'h22, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    for (int i = 1; i <= 5; i++) send_byte(8'(i * 8'h11), 1);
    partial(5);
    send_byte(8'hA5, 0);
    send_byte(8'h81, 0); send_byte(8'h55, 1); send_byte(8'hAF, 0);

    // Four bits of 81 left dangling, then a reset.
    dc = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    repeat (6) @(posedge clk);
    do_reset();
    check_reset();
    send_byte(8'hFF, 0);
    send_byte(8'hA7, 0);

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      send_byte(8'($urandom), 1);
      else if (r < 70) send_byte(ops[$urandom_range(0, 29)], 0);
      else if (r < 92) send_byte(8'($urandom), 0);
      else             partial($urandom_range(1, 7));
    end

    for (int i = 0; i < 200 && expq.size() != 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions never matched by rx_valid, expected 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
